// File: rtl/player_move_ctrl_pkg.sv
// Shared game parameters for the player movement path: map size, FSM state
// encodings, direction codes and the one-step target helper.
package player_move_ctrl_pkg;

  localparam int GAME_MAP_WIDTH  = 11;
  localparam int GAME_MAP_HEIGHT = 11;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ASK  = 2'd1;
  localparam logic [1:0] ST_WAIT = 2'd2;

  localparam logic [1:0] DIR_UP    = 2'd0;
  localparam logic [1:0] DIR_DOWN  = 2'd1;
  localparam logic [1:0] DIR_LEFT  = 2'd2;
  localparam logic [1:0] DIR_RIGHT = 2'd3;

  // One extra bit so that stepping off the low edge wraps to a large value
  // and fails the same unsigned compare as stepping off the high edge.
  typedef struct packed {
    logic [4:0] x;
    logic [4:0] y;
  } coord5_t;

  function automatic coord5_t step_target(input logic [1:0] dir,
                                          input logic [3:0] x,
                                          input logic [3:0] y);
    coord5_t t;
    t.x = {1'b0, x};
    t.y = {1'b0, y};
    case (dir)
      DIR_UP:    t.y = {1'b0, y} - 5'd1;
      DIR_DOWN:  t.y = {1'b0, y} + 5'd1;
      DIR_LEFT:  t.x = {1'b0, x} - 5'd1;
      default:   t.x = {1'b0, x} + 5'd1;
    endcase
    return t;
  endfunction

endpackage

// File: rtl/player_move_ctrl_move_target_calc.sv
// Combinational direction pick (key press over pending entry), one-step
// target computation and map bounds test.
module move_target_calc
  import player_move_ctrl_pkg::*;
#(
  parameter int MAP_WIDTH  = GAME_MAP_WIDTH,
  parameter int MAP_HEIGHT = GAME_MAP_HEIGHT
) (
  input  logic       key_up,
  input  logic       key_down,
  input  logic       key_left,
  input  logic       key_right,
  input  logic       pend_valid,
  input  logic [1:0] pend_dir,
  input  logic [3:0] cur_x,
  input  logic [3:0] cur_y,
  output logic       key_hit,
  output logic [1:0] key_dir,
  output logic       req_valid,
  output logic [3:0] tgt_x,
  output logic [3:0] tgt_y,
  output logic       tgt_ok
);

  logic [1:0] sel_dir;
  coord5_t    tgt;

  always_comb begin
    key_hit = key_up | key_down | key_left | key_right;
    key_dir = DIR_RIGHT;
    if (key_up)        key_dir = DIR_UP;
    else if (key_down) key_dir = DIR_DOWN;
    else if (key_left) key_dir = DIR_LEFT;

    sel_dir   = key_hit ? key_dir : pend_dir;
    req_valid = key_hit | pend_valid;

    tgt    = step_target(sel_dir, cur_x, cur_y);
    tgt_x  = tgt.x[3:0];
    tgt_y  = tgt.y[3:0];
    tgt_ok = req_valid && (tgt.x < 5'(MAP_WIDTH)) && (tgt.y < 5'(MAP_HEIGHT));
  end

endmodule

// File: rtl/player_move_ctrl.sv
// Player movement controller: turns key presses into move requests to the
// interaction stage and commits the returned player state.
//
// state | meaning
// IDLE  | pick key press or pending entry, bounds-check, register target
// ASK   | one-cycle player_ask_move, clear wait timer
// WAIT  | wait for accept_move (commit) or timer expiry (timeout_err)
module player_move_ctrl
  import player_move_ctrl_pkg::*;
#(
  parameter int          MAP_WIDTH   = GAME_MAP_WIDTH,
  parameter int          MAP_HEIGHT  = GAME_MAP_HEIGHT,
  parameter logic [3:0]  INIT_X      = 4'd5,
  parameter logic [3:0]  INIT_Y      = 4'd10,
  parameter logic [15:0] INIT_FLOOR  = 16'd0,
  parameter logic [3:0]  INIT_KEYS   = 4'd0,
  parameter logic [15:0] INIT_HEALTH = 16'd1000,
  parameter int          TIMEOUT     = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        key_up,
  input  logic        key_down,
  input  logic        key_left,
  input  logic        key_right,
  output logic        player_ask_move,
  output logic [3:0]  player_ask_x,
  output logic [3:0]  player_ask_y,
  input  logic        accept_move,
  input  logic [3:0]  goto_x,
  input  logic [3:0]  goto_y,
  input  logic [3:0]  key_num_in,
  input  logic [15:0] floor_in,
  input  logic [15:0] health_in,
  output logic [3:0]  player_x,
  output logic [3:0]  player_y,
  output logic [3:0]  key_num,
  output logic [15:0] floor,
  output logic [15:0] health,
  output logic        busy,
  output logic        dead,
  output logic        timeout_err
);

  localparam int TIMER_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT - 1);

  logic [1:0]         state;
  logic [TIMER_W-1:0] timer;
  logic               pend_valid;
  logic [1:0]         pend_dir;
  logic [3:0]         ask_x;
  logic [3:0]         ask_y;

  logic       key_hit;
  logic [1:0] key_dir;
  logic       req_valid;
  logic [3:0] tgt_x;
  logic [3:0] tgt_y;
  logic       tgt_ok;

  assign dead            = (health == 16'd0);
  assign busy            = (state != ST_IDLE);
  assign player_ask_move = (state == ST_ASK);
  assign player_ask_x    = ask_x;
  assign player_ask_y    = ask_y;

  // A dead player contributes neither fresh presses nor buffered ones.
  move_target_calc #(
    .MAP_WIDTH  (MAP_WIDTH),
    .MAP_HEIGHT (MAP_HEIGHT)
  ) u_calc (
    .key_up     (key_up    & ~dead),
    .key_down   (key_down  & ~dead),
    .key_left   (key_left  & ~dead),
    .key_right  (key_right & ~dead),
    .pend_valid (pend_valid & ~dead),
    .pend_dir   (pend_dir),
    .cur_x      (player_x),
    .cur_y      (player_y),
    .key_hit    (key_hit),
    .key_dir    (key_dir),
    .req_valid  (req_valid),
    .tgt_x      (tgt_x),
    .tgt_y      (tgt_y),
    .tgt_ok     (tgt_ok)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      timer       <= '0;
      pend_valid  <= 1'b0;
      pend_dir    <= DIR_UP;
      ask_x       <= 4'd0;
      ask_y       <= 4'd0;
      timeout_err <= 1'b0;
      player_x    <= INIT_X;
      player_y    <= INIT_Y;
      floor       <= INIT_FLOOR;
      key_num     <= INIT_KEYS;
      health      <= INIT_HEALTH;
    end else begin
      timeout_err <= 1'b0;
      case (state)
        ST_IDLE: begin
          pend_valid <= 1'b0;
          if (tgt_ok) begin
            ask_x <= tgt_x;
            ask_y <= tgt_y;
            state <= ST_ASK;
          end
        end
        ST_ASK: begin
          timer <= '0;
          state <= ST_WAIT;
        end
        ST_WAIT: begin
          if (accept_move) begin
            player_x <= goto_x;
            player_y <= goto_y;
            floor    <= floor_in;
            key_num  <= key_num_in;
            health   <= health_in;
            state    <= ST_IDLE;
          end else if (timer == TIMER_LAST) begin
            timeout_err <= 1'b1;
            state       <= ST_IDLE;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase

      // Presses during a request in flight land in the one-entry buffer.
      if (state != ST_IDLE) begin
        if (dead) begin
          pend_valid <= 1'b0;
        end else if (key_hit) begin
          pend_valid <= 1'b1;
          pend_dir   <= key_dir;
        end
      end
    end
  end

endmodule

// File: tb/tb_player_move_ctrl.sv
// Directed self-checking bench for player_move_ctrl.
module tb_player_move_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        key_up = 0, key_down = 0, key_left = 0, key_right = 0;
  logic        accept_move = 0;
  logic [3:0]  goto_x = 0, goto_y = 0, key_num_in = 0;
  logic [15:0] floor_in = 0, health_in = 0;
  logic        player_ask_move;
  logic [3:0]  player_ask_x, player_ask_y;
  logic [3:0]  player_x, player_y, key_num;
  logic [15:0] floor, health;
  logic        busy, dead, timeout_err;

  int checks = 0;
  int errors = 0;
  int ask_cnt = 0;
  int to_cnt = 0;
  int c0;
  logic [3:0] last_ask_x = 0, last_ask_y = 0;

  player_move_ctrl dut (
    .clk(clk), .rst(rst),
    .key_up(key_up), .key_down(key_down), .key_left(key_left), .key_right(key_right),
    .player_ask_move(player_ask_move), .player_ask_x(player_ask_x), .player_ask_y(player_ask_y),
    .accept_move(accept_move), .goto_x(goto_x), .goto_y(goto_y), .key_num_in(key_num_in),
    .floor_in(floor_in), .health_in(health_in),
    .player_x(player_x), .player_y(player_y), .key_num(key_num), .floor(floor), .health(health),
    .busy(busy), .dead(dead), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (player_ask_move === 1'b1) begin
      ask_cnt    = ask_cnt + 1;
      last_ask_x = player_ask_x;
      last_ask_y = player_ask_y;
    end
    if (timeout_err === 1'b1) to_cnt = to_cnt + 1;
  end

  task automatic set_key(input logic [1:0] dir, input logic v);
    case (dir)
      2'd0: key_up = v;
      2'd1: key_down = v;
      2'd2: key_left = v;
      default: key_right = v;
    endcase
  endtask

  task automatic do_move(input logic [1:0] dir, input logic [3:0] gx, input logic [3:0] gy,
                         input logic [15:0] hin);
    @(negedge clk); set_key(dir, 1'b1);
    @(negedge clk); set_key(dir, 1'b0);
    @(negedge clk); accept_move = 1; goto_x = gx; goto_y = gy; health_in = hin;
    @(negedge clk); accept_move = 0;
  endtask

  task automatic test_reset();
    rst = 1;
    repeat (2) @(negedge clk);
    checks++; if ({player_x, player_y} !== {4'd5, 4'd10}) begin errors++;
      $display("FAIL reset_pos: got %0d,%0d expected 5,10", player_x, player_y); end
    checks++; if ({floor, key_num, health} !== {16'd0, 4'd0, 16'd1000}) begin errors++;
      $display("FAIL reset_state: got floor=%0d keys=%0d health=%0d expected 0,0,1000", floor, key_num, health); end
    checks++; if ({busy, player_ask_move, timeout_err, dead} !== 4'b0000) begin errors++;
      $display("FAIL reset_flags: got %b expected 0000", {busy, player_ask_move, timeout_err, dead}); end
    checks++; if ({player_ask_x, player_ask_y} !== 8'h00) begin errors++;
      $display("FAIL reset_ask_xy: got %0d,%0d expected 0,0", player_ask_x, player_ask_y); end
    rst = 0;
  endtask

  task automatic test_basic_move();
    c0 = ask_cnt;
    @(negedge clk); key_up = 1;
    @(negedge clk); key_up = 0;
    checks++; if (player_ask_move !== 1'b1 || {player_ask_x, player_ask_y} !== {4'd5, 4'd9}) begin errors++;
      $display("FAIL basic_ask: got ask=%b at %0d,%0d expected 1 at 5,9", player_ask_move, player_ask_x, player_ask_y); end
    @(negedge clk);
    checks++; if (player_ask_move !== 1'b0 || busy !== 1'b1) begin errors++;
      $display("FAIL basic_wait: got ask=%b busy=%b expected 0,1", player_ask_move, busy); end
    @(negedge clk); accept_move = 1; goto_x = 5; goto_y = 9; health_in = 990; floor_in = 3; key_num_in = 2;
    @(negedge clk); accept_move = 0;
    checks++; if ({player_x, player_y, health} !== {4'd5, 4'd9, 16'd990}) begin errors++;
      $display("FAIL basic_commit: got %0d,%0d h=%0d expected 5,9 h=990", player_x, player_y, health); end
    checks++; if ({floor, key_num, busy} !== {16'd3, 4'd2, 1'b0}) begin errors++;
      $display("FAIL basic_misc: got floor=%0d keys=%0d busy=%b expected 3,2,0", floor, key_num, busy); end
    repeat (3) @(negedge clk);
    checks++; if (ask_cnt - c0 !== 1) begin errors++;
      $display("FAIL basic_ask_count: got %0d expected 1", ask_cnt - c0); end
  endtask

  task automatic test_bounds();
    do_move(2'd0, 4'd0, 4'd3, 16'd990);
    c0 = ask_cnt;
    @(negedge clk); key_left = 1;
    @(negedge clk); key_left = 0;
    repeat (3) @(negedge clk);
    checks++; if (ask_cnt !== c0 || busy !== 1'b0 || {player_x, player_y} !== {4'd0, 4'd3}) begin errors++;
      $display("FAIL bounds_left: got asks=%0d busy=%b pos=%0d,%0d expected 0,0,0,3", ask_cnt - c0, busy, player_x, player_y); end
    do_move(2'd0, 4'd10, 4'd3, 16'd990);
    c0 = ask_cnt;
    @(negedge clk); key_right = 1;
    @(negedge clk); key_right = 0;
    repeat (3) @(negedge clk);
    checks++; if (ask_cnt !== c0 || busy !== 1'b0 || {player_x, player_y} !== {4'd10, 4'd3}) begin errors++;
      $display("FAIL bounds_right: got asks=%0d busy=%b pos=%0d,%0d expected 0,0,10,3", ask_cnt - c0, busy, player_x, player_y); end
    do_move(2'd2, 4'd10, 4'd3, 16'd990);
    checks++; if ({last_ask_x, last_ask_y} !== {4'd9, 4'd3}) begin errors++;
      $display("FAIL bounds_edge_left: got %0d,%0d expected 9,3", last_ask_x, last_ask_y); end
  endtask

  task automatic test_priority();
    do_move(2'd0, 4'd5, 4'd5, 16'd990);
    c0 = ask_cnt;
    @(negedge clk); key_up = 1; key_right = 1;
    @(negedge clk); key_up = 0; key_right = 0;
    checks++; if (player_ask_move !== 1'b1 || {player_ask_x, player_ask_y} !== {4'd5, 4'd4}) begin errors++;
      $display("FAIL priority_ask: got ask=%b at %0d,%0d expected 1 at 5,4", player_ask_move, player_ask_x, player_ask_y); end
    @(negedge clk); accept_move = 1; goto_x = 5; goto_y = 4; health_in = 990;
    @(negedge clk); accept_move = 0;
    repeat (4) @(negedge clk);
    checks++; if (ask_cnt - c0 !== 1 || busy !== 1'b0) begin errors++;
      $display("FAIL priority_count: got asks=%0d busy=%b expected 1,0", ask_cnt - c0, busy); end
  endtask

  task automatic test_pending();
    c0 = ask_cnt;
    @(negedge clk); key_up = 1;
    @(negedge clk); key_up = 0;
    @(negedge clk); key_down = 1;
    @(negedge clk); key_down = 0; key_left = 1;
    @(negedge clk); key_left = 0; accept_move = 1; goto_x = 5; goto_y = 4; health_in = 990;
    @(negedge clk); accept_move = 0;
    checks++; if (busy !== 1'b0) begin errors++;
      $display("FAIL pending_idle: got busy=%b expected 0", busy); end
    @(negedge clk);
    checks++; if (player_ask_move !== 1'b1 || {player_ask_x, player_ask_y} !== {4'd4, 4'd4}) begin errors++;
      $display("FAIL pending_ask: got ask=%b at %0d,%0d expected 1 at 4,4", player_ask_move, player_ask_x, player_ask_y); end
    @(negedge clk); accept_move = 1; goto_x = 4; goto_y = 4;
    @(negedge clk); accept_move = 0;
    repeat (5) @(negedge clk);
    checks++; if (ask_cnt - c0 !== 2 || busy !== 1'b0 || player_x !== 4'd4) begin errors++;
      $display("FAIL pending_count: got asks=%0d busy=%b x=%0d expected 2,0,4", ask_cnt - c0, busy, player_x); end
  endtask

  task automatic test_timeout();
    c0 = to_cnt;
    @(negedge clk); key_right = 1;
    @(negedge clk); key_right = 0;
    repeat (15) @(negedge clk);
    checks++; if (busy !== 1'b1 || timeout_err !== 1'b0) begin errors++;
      $display("FAIL timeout_last_wait: got busy=%b err=%b expected 1,0", busy, timeout_err); end
    @(negedge clk);
    checks++; if (timeout_err !== 1'b1 || busy !== 1'b0) begin errors++;
      $display("FAIL timeout_pulse: got err=%b busy=%b expected 1,0", timeout_err, busy); end
    @(negedge clk);
    checks++; if (timeout_err !== 1'b0 || to_cnt - c0 !== 1 || {player_x, player_y} !== {4'd4, 4'd4}) begin errors++;
      $display("FAIL timeout_after: got err=%b pulses=%0d pos=%0d,%0d expected 0,1,4,4", timeout_err, to_cnt - c0, player_x, player_y); end
  endtask

  task automatic test_accept_at_timeout();
    c0 = to_cnt;
    @(negedge clk); key_up = 1;
    @(negedge clk); key_up = 0;
    repeat (15) @(negedge clk);
    accept_move = 1; goto_x = 4; goto_y = 3; health_in = 990;
    @(negedge clk); accept_move = 0;
    checks++; if (timeout_err !== 1'b0 || player_y !== 4'd3 || busy !== 1'b0) begin errors++;
      $display("FAIL race_accept: got err=%b y=%0d busy=%b expected 0,3,0", timeout_err, player_y, busy); end
    @(negedge clk);
    checks++; if (to_cnt !== c0) begin errors++;
      $display("FAIL race_no_timeout: got %0d pulses expected 0", to_cnt - c0); end
  endtask

  task automatic test_reset_mid_wait();
    @(negedge clk); accept_move = 1; goto_x = 1; goto_y = 1;
    @(negedge clk); accept_move = 0;
    checks++; if ({player_x, player_y} !== {4'd4, 4'd3}) begin errors++;
      $display("FAIL idle_accept_ignored: got %0d,%0d expected 4,3", player_x, player_y); end
    @(negedge clk); key_left = 1;
    @(negedge clk); key_left = 0;
    @(negedge clk); rst = 1;
    @(negedge clk); rst = 0;
    checks++; if (busy !== 1'b0 || {player_x, player_y} !== {4'd5, 4'd10} || {player_ask_x, player_ask_y} !== 8'h00) begin errors++;
      $display("FAIL midwait_reset: got busy=%b pos=%0d,%0d ask=%0d,%0d expected 0,5,10,0,0", busy, player_x, player_y, player_ask_x, player_ask_y); end
    @(negedge clk); accept_move = 1; goto_x = 1; goto_y = 1;
    @(negedge clk); accept_move = 0;
    checks++; if ({player_x, player_y} !== {4'd5, 4'd10} || busy !== 1'b0) begin errors++;
      $display("FAIL midwait_late_accept: got %0d,%0d busy=%b expected 5,10,0", player_x, player_y, busy); end
  endtask

  task automatic test_dead();
    c0 = ask_cnt;
    @(negedge clk); key_up = 1;
    @(negedge clk); key_up = 0;
    @(negedge clk); key_left = 1;
    @(negedge clk); key_left = 0; accept_move = 1; goto_x = 5; goto_y = 9; health_in = 0;
    @(negedge clk); accept_move = 0;
    checks++; if (dead !== 1'b1 || health !== 16'd0) begin errors++;
      $display("FAIL dead_flag: got dead=%b health=%0d expected 1,0", dead, health); end
    repeat (3) @(negedge clk);
    key_down = 1;
    @(negedge clk); key_down = 0;
    repeat (3) @(negedge clk);
    checks++; if (ask_cnt - c0 !== 1 || busy !== 1'b0) begin errors++;
      $display("FAIL dead_no_ask: got asks=%0d busy=%b expected 1,0", ask_cnt - c0, busy); end
    rst = 1;
    @(negedge clk); rst = 0;
    checks++; if (health !== 16'd1000 || dead !== 1'b0) begin errors++;
      $display("FAIL dead_reset: got health=%0d dead=%b expected 1000,0", health, dead); end
  endtask

  initial begin
    test_reset();
    test_basic_move();
    test_bounds();
    test_priority();
    test_pending();
    test_timeout();
    test_accept_at_timeout();
    test_reset_mid_wait();
    test_dead();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
